rx_tlp_framer: RTL and testbench



---
 rtl/rx_tlp_pkg.sv | 31 +++
 rtl/rx_sync_fifo.sv | 54 +++++
 rtl/rx_tlp_framer.sv | 174 +++++++++++++++++
 tb/tb_rx_tlp_framer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_tlp_pkg.sv
// rx_tlp_pkg: shared symbols, FSM encoding and FIFO entry layout for the
// receive-side TLP framer.
package rx_tlp_pkg;

   localparam logic [7:0]  STP_SYM   = 8'hFB;
   localparam logic [7:0]  END_SYM   = 8'hFD;
   localparam logic [31:0] IDLE_WORD = 32'hBCBCBCBC;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PAYLOAD,
      ST_END_CHK,
      ST_DISCARD
   } state_e;

   // One buffered payload word with its framing tags.
   typedef struct packed {
      logic        err;
      logic        eop;
      logic        sop;
      logic [31:0] data;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   // XOR of the four bytes of a word.
   function automatic logic [7:0] fold_xor(input logic [31:0] w);
      return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
   endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// rx_sync_fifo: single-clock show-ahead FIFO. The head entry is read
// combinationally at the read pointer; pointers carry one extra wrap bit so
// full and empty are told apart by the MSB.
module rx_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 35,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q;
   logic [AW:0]      rptr_q;
   logic             full_w;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (wptr_q == rptr_q);
   assign full_w  = (wptr_q[AW] != rptr_q[AW]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign count_o = wptr_q - rptr_q;
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   // A pop frees the slot in the same cycle, so push is allowed even when full.
   assign do_push = push_i && (!full_w || pop_i);
   assign do_pop  = pop_i && !empty_o;

   // Storage array; written only, never reset.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wptr_q[AW-1:0]] <= wdata_i;
      end
   end

   // Pointer update; reset flushes the FIFO.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + (AW + 1)'(1);
         if (do_pop)  rptr_q <= rptr_q + (AW + 1)'(1);
      end
   end

endmodule

// File: rtl/rx_tlp_framer.sv
// rx_tlp_framer: strips idle words, frames payload between STP and END
// markers, reserves FIFO space per frame and tags buffered words with
// sop/eop/err. Optional payload checksum: define RX_TLP_FRAMER_CHK_EN.
module rx_tlp_framer
   import rx_tlp_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int MAX_LEN = 8
) (
   input  logic        clock1,
   input  logic        reset,
   input  logic [31:0] data_in,
   input  logic        valid_in,
   output logic [31:0] data_out,
   output logic        valid_out,
   input  logic        ready_in,
   output logic        sop_out,
   output logic        eop_out,
   output logic        err_out,
   output logic        frame_ok,
   output logic        frame_err,
   output logic        ovf_drop
);

   localparam int AW = $clog2(DEPTH);

   state_e      state_q;
   logic [15:0] len_q;
   logic [15:0] cnt_q;
   logic [31:0] held_q;
   logic        push_q;
   entry_t      wentry_q;
   logic        frame_ok_q;
   logic        frame_err_q;
   logic        ovf_drop_q;

   logic [ENTRY_W-1:0] fifo_rdata;
   entry_t             head;
   logic               fifo_empty;
   logic [AW:0]        occ;
   logic [15:0]        len_w;
   logic [31:0]        free_w;
   logic               len_ok;
   logic               fits;
   logic               start_ok;
   logic               chk_pass;
   logic               end_good;

   rx_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk_i   (clock1),
      .rst_i   (reset),
      .push_i  (push_q),
      .wdata_i (wentry_q),
      .pop_i   (valid_out && ready_in),
      .rdata_o (fifo_rdata),
      .empty_o (fifo_empty),
      .count_o (occ)
   );

   // Head outputs are forced to zero while the FIFO is empty so stale memory
   // never leaks out after reset.
   assign head      = fifo_rdata;
   assign valid_out = !fifo_empty;
   assign data_out  = valid_out ? head.data : 32'h0;
   assign sop_out   = valid_out && head.sop;
   assign eop_out   = valid_out && head.eop;
   assign err_out   = valid_out && head.err;

   assign frame_ok  = frame_ok_q;
   assign frame_err = frame_err_q;
   assign ovf_drop  = ovf_drop_q;

   // Free space counts a write still in flight from the previous frame's END.
   assign len_w    = data_in[15:0];
   assign free_w   = 32'(DEPTH) - 32'(occ) - 32'(push_q);
   assign len_ok   = (len_w != 16'd0) && (32'(len_w) <= 32'(MAX_LEN));
   assign fits     = free_w >= 32'(len_w);
   assign start_ok = valid_in && (state_q == ST_IDLE) &&
                     (data_in[31:24] == STP_SYM) && len_ok && fits;

`ifdef RX_TLP_FRAMER_CHK_EN
   logic [7:0] chk_q;
   logic [7:0] chk_d;

   // Running XOR over every payload byte; cleared when a frame is accepted.
   always_comb begin
      chk_d = chk_q;
      if (start_ok) begin
         chk_d = 8'h00;
      end else if (valid_in && (state_q == ST_PAYLOAD)) begin
         chk_d = chk_q ^ fold_xor(data_in);
      end
   end

   // Checksum accumulator register.
   always_ff @(posedge clock1) begin
      chk_q <= chk_d;
   end

   assign chk_pass = (data_in[7:0] == chk_q);
`else
   assign chk_pass = 1'b1;
`endif

   assign end_good = (data_in[31:24] == END_SYM) && chk_pass;

   // Framing FSM with registered FIFO write and registered status pulses.
   always_ff @(posedge clock1) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         push_q      <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         ovf_drop_q  <= 1'b0;
      end else begin
         push_q      <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         ovf_drop_q  <= 1'b0;
         if (valid_in) begin
            unique case (state_q)
               ST_IDLE: begin
                  if (data_in == IDLE_WORD) begin
                     state_q <= ST_IDLE;
                  end else if ((data_in[31:24] == STP_SYM) && len_ok) begin
                     len_q <= len_w;
                     cnt_q <= '0;
                     if (fits) begin
                        state_q <= ST_PAYLOAD;
                     end else begin
                        ovf_drop_q <= 1'b1;
                        state_q    <= ST_DISCARD;
                     end
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end
               ST_PAYLOAD: begin
                  cnt_q <= cnt_q + 16'd1;
                  if (cnt_q == len_q - 16'd1) begin
                     // Last word waits for the END so its err tag is known.
                     held_q  <= data_in;
                     state_q <= ST_END_CHK;
                  end else begin
                     push_q   <= 1'b1;
                     wentry_q <= '{err: 1'b0, eop: 1'b0,
                                   sop: (cnt_q == 16'd0), data: data_in};
                  end
               end
               ST_END_CHK: begin
                  push_q   <= 1'b1;
                  wentry_q <= '{err: !end_good, eop: 1'b1,
                                sop: (len_q == 16'd1), data: held_q};
                  if (end_good) frame_ok_q  <= 1'b1;
                  else          frame_err_q <= 1'b1;
                  state_q <= ST_IDLE;
               end
               ST_DISCARD: begin
                  // len payload words followed by the unchecked END.
                  cnt_q <= cnt_q + 16'd1;
                  if (cnt_q == len_q) state_q <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rx_tlp_framer.sv
// tb_rx_tlp_framer: directed scenarios followed by randomized frames, checked
// against a frame-level reference model (expected output entry queue plus
// expected status pulse per input word).
`timescale 1ns/1ps
module tb_rx_tlp_framer;

   localparam int DEPTH   = 16;
   localparam int MAX_LEN = 8;
`ifdef RX_TLP_FRAMER_CHK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   localparam logic [2:0] P_NONE = 3'b000;
   localparam logic [2:0] P_OK   = 3'b100;
   localparam logic [2:0] P_ERR  = 3'b010;
   localparam logic [2:0] P_OVF  = 3'b001;
   localparam logic [31:0] IDLE_W = 32'hBCBCBCBC;

   logic        clock1 = 1'b0;
   logic        reset;
   logic [31:0] data_in;
   logic        valid_in;
   logic        ready_in;
   logic [31:0] data_out;
   logic        valid_out;
   logic        sop_out, eop_out, err_out;
   logic        frame_ok, frame_err, ovf_drop;

   int checks   = 0;
   int failures = 0;
   int ready_mode = 1;          // 0: never ready, 1: always ready, 2: random

   logic [34:0] exp_q[$];       // {err, eop, sop, data}
   logic [31:0] pay [MAX_LEN+2];

   rx_tlp_framer #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
      .clock1    (clock1),
      .reset     (reset),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .ready_in  (ready_in),
      .sop_out   (sop_out),
      .eop_out   (eop_out),
      .err_out   (err_out),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .ovf_drop  (ovf_drop)
   );

   always #5 clock1 = ~clock1;

   task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic rdy();
      if (ready_mode == 0) return 1'b0;
      if (ready_mode == 1) return 1'b1;
      return 1'($urandom_range(0, 1));
   endfunction

   // One clock: drive at negedge, check head on handshake, check pulses after edge.
   task automatic tick(input logic v, input logic [31:0] d, input logic r, input logic [2:0] ex);
      valid_in = v;
      data_in  = d;
      ready_in = r;
      #1;
      if (valid_out && r) begin
         if (exp_q.size() == 0) check("unexpected_out", 35'(valid_out), 35'(0));
         else check("head", {err_out, eop_out, sop_out, data_out}, exp_q.pop_front());
      end
      @(posedge clock1);
      @(negedge clock1);
      check("pulses", {frame_ok, frame_err, ovf_drop}, ex);
   endtask

   function automatic logic [7:0] pay_xor(input int len);
      logic [7:0] x = 8'h00;
      for (int i = 0; i < len; i++)
         x ^= pay[i][31:24] ^ pay[i][23:16] ^ pay[i][15:8] ^ pay[i][7:0];
      return x;
   endfunction

   function automatic logic [31:0] good_end(input int len);
      return {8'hFD, 16'h0000, pay_xor(len)};
   endfunction

   task automatic rand_payload(input int len);
      for (int i = 0; i < len; i++) begin
         pay[i] = $urandom;
         case ($urandom_range(0, 7))
            0: pay[i][31:24] = 8'hFB;
            1: pay[i][31:24] = 8'hFD;
            2: pay[i] = IDLE_W;
            default: ;
         endcase
      end
   endtask

   // Frame-level model: decides accept / drop / reject from the rules and
   // queues the tagged entries an accepted frame must produce.
   task automatic send_frame(input int len, input logic [31:0] end_w, input bit gaps);
      bit lenok, fits, bad;
      int occ;
      logic [2:0] ex;
      occ   = exp_q.size();
      lenok = (len >= 1) && (len <= MAX_LEN);
      fits  = (DEPTH - occ) >= len;
      ex    = !lenok ? P_ERR : (!fits ? P_OVF : P_NONE);
      tick(1'b1, {8'hFB, 8'($urandom), 16'(len)}, 1'b0, ex);
      if (!lenok) return;
      bad = (end_w[31:24] != 8'hFD) || (CHK_EN && (end_w[7:0] != pay_xor(len)));
      if (fits)
         for (int i = 0; i < len; i++)
            exp_q.push_back({(bad && i == len - 1), (i == len - 1), (i == 0), pay[i]});
      for (int i = 0; i < len; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) tick(1'b0, $urandom, rdy(), P_NONE);
         tick(1'b1, pay[i], rdy(), P_NONE);
      end
      tick(1'b1, end_w, rdy(), fits ? (bad ? P_ERR : P_OK) : P_NONE);
      repeat (3) tick(1'b0, $urandom, rdy(), P_NONE);
   endtask

   initial begin
      int kind, len;
      logic [31:0] w;
      reset = 1'b1;
      valid_in = 1'b0;
      data_in = 32'h0;
      ready_in = 1'b0;
      @(negedge clock1);
      tick(1'b0, 32'h0, 1'b0, P_NONE);
      tick(1'b1, 32'hFB000001, 1'b0, P_NONE);
      check("rst_valid", 35'(valid_out), 35'(0));
      check("rst_head", {err_out, eop_out, sop_out, data_out}, 35'(0));
      reset = 1'b0;

      // Basic 3-word frame with idle words ahead and first-word latency.
      ready_mode = 1;
      exp_q.push_back({3'b001, 32'h11111111});
      exp_q.push_back({3'b000, 32'h22222222});
      exp_q.push_back({3'b010, 32'h33333333});
      tick(1'b1, IDLE_W, 1'b1, P_NONE);
      tick(1'b1, IDLE_W, 1'b1, P_NONE);
      tick(1'b1, 32'hFB000003, 1'b1, P_NONE);
      tick(1'b1, 32'h11111111, 1'b1, P_NONE);
      check("lat_before", 35'(valid_out), 35'(0));
      tick(1'b1, 32'h22222222, 1'b1, P_NONE);
      check("lat_after", {valid_out, sop_out, data_out}, {1'b1, 1'b1, 32'h11111111});
      tick(1'b1, 32'h33333333, 1'b1, P_NONE);
      tick(1'b1, 32'hFD000000, 1'b1, P_OK);
      repeat (3) tick(1'b0, 32'h0, 1'b1, P_NONE);

      // len=1 with a bad END marker.
      pay[0] = 32'h5A5A5A5A;
      send_frame(1, 32'hAA000000, 1'b0);

      // Overflow drop with the consumer stalled, then a frame that just fits.
      ready_mode = 0;
      rand_payload(8);
      send_frame(8, good_end(8), 1'b0);
      rand_payload(2);
      send_frame(2, good_end(2), 1'b0);
      rand_payload(8);
      send_frame(8, good_end(8), 1'b0);
      rand_payload(6);
      send_frame(6, good_end(6), 1'b0);
      ready_mode = 1;
      repeat (20) tick(1'b0, 32'h0, 1'b1, P_NONE);
      check("ovf_drained", 35'(exp_q.size()), 35'(0));
      check("ovf_vld", 35'(valid_out), 35'(0));

      // Reset in the middle of a payload.
      rand_payload(5);
      tick(1'b1, 32'hFB000005, 1'b1, P_NONE);
      tick(1'b1, pay[0], 1'b1, P_NONE);
      tick(1'b1, pay[1], 1'b1, P_NONE);
      reset = 1'b1;
      tick(1'b1, pay[2], 1'b0, P_NONE);
      reset = 1'b0;
      exp_q.delete();
      check("rst_mid_vld", 35'(valid_out), 35'(0));
      check("rst_mid_head", {err_out, eop_out, sop_out, data_out}, 35'(0));
      rand_payload(4);
      send_frame(4, good_end(4), 1'b0);

      // Checksum pass / mismatch (mismatch is only an error when enabled).
      pay[0] = 32'h01020304;
      send_frame(1, 32'hFD000004, 1'b0);
      send_frame(1, 32'hFD000005, 1'b0);

      // Illegal lengths and a stray word in IDLE.
      send_frame(0, 32'hFD000000, 1'b0);
      send_frame(9, 32'hFD000000, 1'b0);
      tick(1'b1, 32'h12345678, 1'b1, P_ERR);
      tick(1'b1, IDLE_W, 1'b1, P_NONE);

      // Randomized frames, gaps and backpressure.
      ready_mode = 2;
      for (int f = 0; f < 60; f++) begin
         kind = $urandom_range(0, 9);
         len  = $urandom_range(1, MAX_LEN);
         rand_payload(len);
         if (kind <= 5) begin
            send_frame(len, good_end(len), 1'b1);
         end else if (kind == 6) begin
            w = good_end(len);
            w[31:24] = 8'hA0 | 8'($urandom_range(0, 15));
            send_frame(len, w, 1'b1);
         end else if (kind == 7) begin
            send_frame(len, good_end(len) ^ 32'h00000001, 1'b1);
         end else if (kind == 8) begin
            send_frame(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 300),
                       32'hFD000000, 1'b0);
         end else begin
            w = $urandom;
            if (w[31:24] == 8'hFB) w[31:24] = 8'h00;
            if (w == IDLE_W) w = 32'h0;
            tick(1'b1, w, rdy(), P_ERR);
         end
         repeat ($urandom_range(0, 2))
            if ($urandom_range(0, 1) == 0) tick(1'b1, IDLE_W, rdy(), P_NONE);
            else tick(1'b0, $urandom, rdy(), P_NONE);
      end

      ready_mode = 1;
      repeat (30) tick(1'b0, 32'h0, 1'b1, P_NONE);
      check("final_drained", 35'(exp_q.size()), 35'(0));
      check("final_vld", 35'(valid_out), 35'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
